// File: rtl/cordic_pkg.sv
// Shared Q16.16 CORDIC definitions: constants, arctangent table, FSM state type.
// Used by cordic_vectoring (and the rotation-mode cordic_block).
package cordic_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic signed [DATA_W-1:0] ONE_Q16     = 32'sd65536;
  localparam logic signed [DATA_W-1:0] HALF_PI_Q16 = 32'sd102943;
  localparam logic signed [DATA_W-1:0] PI_Q16      = 32'sd205887;
  localparam logic signed [DATA_W-1:0] K_Q16       = 32'sd107923;
  localparam logic signed [DATA_W-1:0] INV_K_Q16   = 32'sd39797;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // atan(2^-i) in Q16.16 radians; zero beyond i=16
  function automatic logic signed [DATA_W-1:0] atan_q16(input logic [IDX_W-1:0] i);
    logic signed [DATA_W-1:0] a;
    case (i)
      5'd0:    a = 32'sd51472;
      5'd1:    a = 32'sd30386;
      5'd2:    a = 32'sd16055;
      5'd3:    a = 32'sd8150;
      5'd4:    a = 32'sd4091;
      5'd5:    a = 32'sd2047;
      5'd6:    a = 32'sd1024;
      5'd7:    a = 32'sd512;
      5'd8:    a = 32'sd256;
      5'd9:    a = 32'sd128;
      5'd10:   a = 32'sd64;
      5'd11:   a = 32'sd32;
      5'd12:   a = 32'sd16;
      5'd13:   a = 32'sd8;
      5'd14:   a = 32'sd4;
      5'd15:   a = 32'sd2;
      5'd16:   a = 32'sd1;
      default: a = 32'sd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-idx) in Q16.16.
// Ports: idx (iteration index), angle_c (angle, combinational).
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic        [IDX_W-1:0]  idx,
  output logic signed [DATA_W-1:0] angle_c
);

  always_comb begin
    angle_c = atan_q16(idx);
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative Q16.16 CORDIC, vectoring mode. Rotates (x0,y0) onto the +x axis:
//   x -> K*|(x0,y0)|, y -> ~0, z -> z0 + atan2(y0,x0). One iteration per clock.
// Ports: clk, rst_n (sync, active low), ready (rising edge starts),
//   x0/y0/z0 operands, n iteration count (clamped to MAX_ITER),
//   x/y/z results (update only when done pulses), busy, done.
// Optional: define CORDIC_VEC_QUAD_CORR_EN to pre-rotate x0<0 inputs by +-pi
//   at load time, giving full-plane atan2 at no extra latency.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned MAX_ITER = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ready,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] y0,
  input  logic signed [DATA_W-1:0] z0,
  input  logic        [DATA_W-1:0] n,
  output logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] z,
  output logic                     busy,
  output logic                     done
);

  state_t state, state_next;

  logic                     ready_q;
  logic signed [DATA_W-1:0] xw, yw, zw;
  logic        [IDX_W-1:0]  iter;
  logic        [IDX_W-1:0]  n_eff;

  logic                     start_c;
  logic        [IDX_W-1:0]  n_clamp_c;
  logic                     load_c, step_c, finish_c;
  logic signed [DATA_W-1:0] lx_c, ly_c, lz_c;
  logic signed [DATA_W-1:0] xn_c, yn_c, zn_c;
  logic signed [DATA_W-1:0] atan_c;

  assign start_c   = ready & ~ready_q;
  assign n_clamp_c = (n > DATA_W'(MAX_ITER)) ? IDX_W'(MAX_ITER) : IDX_W'(n);

  cordic_atan_rom u_rom (
    .idx     (iter),
    .angle_c (atan_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath controls
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          load_c     = 1'b1;
          state_next = (n_clamp_c == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        step_c = 1'b1;
        if (iter == n_eff - IDX_W'(1)) state_next = DONE;
      end
      DONE: begin
        finish_c   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load mux; optional half-plane fold for x0<0
  always_comb begin
    lx_c = x0;
    ly_c = y0;
    lz_c = z0;
`ifdef CORDIC_VEC_QUAD_CORR_EN
    if (x0[DATA_W-1]) begin
      lx_c = -x0;
      ly_c = -y0;
      lz_c = y0[DATA_W-1] ? (z0 - PI_Q16) : (z0 + PI_Q16);
    end
`endif
  end

  // One micro-rotation; drive y toward zero using pre-update values
  always_comb begin
    if (!yw[DATA_W-1]) begin
      xn_c = xw + (yw >>> iter);
      yn_c = yw - (xw >>> iter);
      zn_c = zw + atan_c;
    end else begin
      xn_c = xw - (yw >>> iter);
      yn_c = yw + (xw >>> iter);
      zn_c = zw - atan_c;
    end
  end

  // Working registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      xw      <= '0;
      yw      <= '0;
      zw      <= '0;
      iter    <= '0;
      n_eff   <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ready_q <= ready;
      busy    <= (state_next == ITER) || (state_next == DONE);
      done    <= finish_c;
      if (load_c) begin
        xw    <= lx_c;
        yw    <= ly_c;
        zw    <= lz_c;
        iter  <= '0;
        n_eff <= n_clamp_c;
      end else if (step_c) begin
        xw   <= xn_c;
        yw   <= yn_c;
        zw   <= zn_c;
        iter <= iter + IDX_W'(1);
      end
      if (finish_c) begin
        x <= xw;
        y <= yw;
        z <= zw;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: table-driven operations checked
// through a scoreboard queue, plus hand sequences for busy/ignored-start,
// mid-operation reset and iteration clamping.
module tb_cordic_vectoring;

  localparam int TOL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] x0, y0, z0, n;
  logic [31:0] x, y, z;
  logic        busy, done;

  cordic_vectoring #(.MAX_ITER(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ready (ready),
    .x0    (x0),
    .y0    (y0),
    .z0    (z0),
    .n     (n),
    .x     (x),
    .y     (y),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ix0, iy0, iz0, in;
    int    ex, ey, ez;
    int    tx, ty, tz;
    int    lat;
    bit    chk;
  } row_t;

  typedef struct {
    string name;
    int    t_start;
    int    ex, ey, ez;
    int    tx, ty, tz;
    int    lat;
    bit    chk;
  } exp_t;

  exp_t sb[$];
  row_t rows[8];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   dones  = 0;

  task automatic cmp(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+-%0d)", nm, act, exp, tol);
    end
  endtask

  // Cycle counter and output monitor; samples 1 time unit after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          cmp({e.name, "_latency"}, longint'(cyc - e.t_start), longint'(e.lat), 0);
          if (e.chk) begin
            cmp({e.name, "_x"}, longint'($signed(x)), longint'(e.ex), longint'(e.tx));
            cmp({e.name, "_y"}, longint'($signed(y)), longint'(e.ey), longint'(e.ty));
            cmp({e.name, "_z"}, longint'($signed(z)), longint'(e.ez), longint'(e.tz));
          end
          cmp({e.name, "_busy_at_done"}, longint'(busy), 0, 0);
        end
      end
    end
  end

  // Drive one start edge; returns the cycle on which the DUT samples it
  task automatic start_op(input row_t r, input bit track, output int t0);
    exp_t e;
    @(posedge clk);
    #1;
    x0 = r.ix0; y0 = r.iy0; z0 = r.iz0; n = r.in;
    ready = 1'b1;
    t0 = cyc + 1;
    if (track) begin
      e.name = r.name; e.t_start = t0;
      e.ex = r.ex; e.ey = r.ey; e.ez = r.ez;
      e.tx = r.tx; e.ty = r.ty; e.tz = r.tz;
      e.lat = r.lat; e.chk = r.chk;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_row(input row_t r);
    int t0;
    start_op(r, 1'b1, t0);
    @(posedge clk);
    #1 ready = 1'b0;
    wait_drain(r.name);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int   t0;
    int   d0;
    row_t ra;

    //             name       x0       y0       z0     n    ex      ey  ez     tx  ty  tz  lat chk
    rows[0] = '{"diag45",  65536,   65536,       0,  16, 152625,  0, 51472, TOL, TOL, TOL, 17, 1'b1};
    rows[1] = '{"gain",    65536,       0,       0,  16, 107923,  0,     0, TOL, TOL, TOL, 17, 1'b1};
    rows[2] = '{"n0",     123456,  -54321,     777,   0, 123456, -54321, 777, 0, 0, 0,      1, 1'b1};
    rows[3] = '{"clamp",   65536,   65536,       0, 100, 152625,  0, 51472, TOL, TOL, TOL, 17, 1'b1};
    rows[4] = '{"r345",   196608,  262144,    1000,  16, 539610,  0, 61771,  24,  24,  12, 17, 1'b1};
    rows[5] = '{"n4",      65536,   65536,       0,   4, 151552, -14336, 57653, 0, 0, 0,    5, 1'b1};
    rows[6] = '{"neg45",   65536,  -65536,  102943,  16, 152625,  0, 51471, TOL, TOL, TOL, 17, 1'b1};
`ifdef CORDIC_VEC_QUAD_CORR_EN
    rows[7] = '{"quad2",  -65536,   65536,       0,  16, 152625,  0, 154415, TOL, TOL, TOL, 17, 1'b1};
`else
    rows[7] = '{"quad2",  -65536,   65536,       0,  16, 0,       0, 0,        0,   0,   0, 17, 1'b0};
`endif

    rst_n = 1'b0; ready = 1'b0; x0 = '0; y0 = '0; z0 = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_x", longint'($signed(x)), 0, 0);
    cmp("reset_y", longint'($signed(y)), 0, 0);
    cmp("reset_z", longint'($signed(z)), 0, 0);
    cmp("reset_busy", longint'(busy), 0, 0);
    cmp("reset_done", longint'(done), 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) run_row(rows[i]);

    // Busy window and a second ready edge during the operation
    ra = rows[6];
    ra.name = "busy_seq";
    d0 = dones;
    start_op(ra, 1'b1, t0);
    @(posedge clk);
    #1;
    cmp("busy_at_start", longint'(busy), 1, 0);
    for (int j = 1; j <= 17; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) ready = 1'b0;
      if (j == 4) ready = 1'b1;
      if (j == 6) ready = 1'b0;
      if (j == 16) cmp("busy_last_iter", longint'(busy), 1, 0);
      if (j == 17) cmp("busy_cleared", longint'(busy), 0, 0);
    end
    wait_drain("busy_seq");
    repeat (20) @(posedge clk);
    #1;
    cmp("single_done", longint'(dones - d0), 1, 0);

    // Reset in the middle of an operation: no done, outputs cleared
    ra = rows[4];
    d0 = dones;
    start_op(ra, 1'b0, t0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) ready = 1'b0;
      if (j == 5) rst_n = 1'b0;
    end
    cmp("abort_x", longint'($signed(x)), 0, 0);
    cmp("abort_y", longint'($signed(y)), 0, 0);
    cmp("abort_z", longint'($signed(z)), 0, 0);
    cmp("abort_busy", longint'(busy), 0, 0);
    cmp("abort_done", longint'(done), 0, 0);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    cmp("abort_no_done", longint'(dones - d0), 0, 0);

    ra = rows[0];
    ra.name = "after_reset";
    run_row(ra);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Iterative Q16.16 CORDIC in vectoring mode; the inverse counterpart of the rotation-mode cordic_block.
- Rotates (x0, y0) onto the positive x-axis, accumulating the angle into z.
- Results: x = K*sqrt(x0^2+y0^2) with K ~= 1.64676, y ~= 0, z = z0 + atan2(y0, x0).
- Shares the cordic_block start/operand interface (ready strobe, x0/y0/z0/n, clk) so one driver/bench can target either block.

Parameters:
- MAX_ITER, 16, upper clamp on iteration count; legal range 1..31.
- TOL, 8, bench-only comparison tolerance in LSBs; no RTL effect.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- ready  input  1  start request; a 0->1 transition sampled on clk starts an operation.
- x0  input  32  initial x, signed Q16.16.
- y0  input  32  initial y, signed Q16.16.
- z0  input  32  initial angle, signed Q16.16 radians.
- n  input  32  requested iteration count, unsigned.
- x  output  32  magnitude result (gain-scaled), signed Q16.16.
- y  output  32  residual y, signed Q16.16.
- z  output  32  angle result, signed Q16.16.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when x/y/z become valid.

Behaviour:
- Reset (rst_n=0 at a clk edge): x=y=z=0, busy=0, done=0, FSM=IDLE, iteration counter=0, ready-edge history=0.
- Start detect: ready registered each cycle; start = ready & ~ready_q.
- IDLE:
  - On start: latch x0/y0/z0; latch n clamped to MAX_ITER as n_eff; busy=1; go to ITER.
  - If n_eff==0, go directly to DONE.
- ITER, iteration i = 0..n_eff-1, one per cycle:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - All updates use pre-update values; shifts are arithmetic.
  - After iteration n_eff-1, go to DONE.
- DONE (one cycle): done=1, busy=0, then IDLE.
  - x/y/z outputs update only on entry to DONE and hold until the next DONE or reset; no intermediate values are visible.
- Latency: start cycle T -> done at T+n_eff+1.
- start while busy or in DONE: ignored; no queueing. ready must return to 0 and rise again.
- Reset mid-operation: aborts immediately, no done pulse, outputs cleared.
- Arithmetic: 32-bit two's complement, wrap on overflow (no saturation).
  - Legal inputs: sqrt(x0^2+y0^2) < 2^14 (real) so K-scaled x fits.
  - Convergence requires x0 > 0 unless the optional feature is enabled.
- n beyond MAX_ITER is clamped silently.

Optional Feature:
- Macro: CORDIC_VEC_QUAD_CORR_EN.
- Defined: at load, if x0<0, pre-rotate: x=-x0, y=-y0, z = z0 + PI_Q16 if y0>=0, else z0 - PI_Q16 (PI_Q16=205887). Full-plane atan2 results; costs no extra cycle (done in the load mux).
- Undefined: operands are loaded as-is. x0<0 gives unspecified results; no flag is raised.

Decomposition:
- Package cordic_pkg:
  - Q16.16 constants: ONE_Q16=65536, HALF_PI_Q16=102943, PI_Q16=205887, K_Q16=107923, INV_K_Q16=39797.
  - ATAN table atan(2^-i) for i=0..31: 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, then 0.
  - FSM state typedef {IDLE, ITER, DONE}.
- Sub-module cordic_atan_rom: combinational index->angle lookup; shared with cordic_block.

Test Plan:
- x0=65536, y0=65536, z0=0, n=16 -> done at T+17; z=51472+-8, x=152625+-8, |y|<=8.
- x0=65536, y0=0, z0=0, n=16 -> z=0+-8, x=107923+-8 (pure gain K).
- x0=65536, y0=-65536, z0=102943, n=16 -> z=51471+-8; busy high T..T+16; second ready edge at T+5 ignored (single done).
- n=0 -> done at T+1, outputs equal x0/y0/z0. n=100 -> clamped, done at T+17.
- Assert rst_n=0 at T+6 mid-operation -> no done; x=y=z=0, busy=0; a fresh start afterwards completes normally.
- With CORDIC_VEC_QUAD_CORR_EN: x0=-65536, y0=65536 -> z=154415+-8 (3pi/4), x=152625+-8. Without the macro, the same input gives no check beyond one done pulse.
